// File: rtl/fht_pkg.sv
// Shared types and latency constants for the FHT datapath (address generator and butterfly).
package fht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fht_state_e;

    // Write strobe trails the x1/x2 issue by one RAM read plus the butterfly pipeline.
    localparam int RAM_RD_LAT = 1;
    localparam int BUT_LAT    = 2;
    localparam int WR_DLY_DEF = RAM_RD_LAT + BUT_LAT;

endpackage

// File: rtl/fht_dly_line.sv
// Resettable fixed-depth shift register used to align issue-time values with later pipeline slots.
module fht_dly_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/fht_addr_gen.sv
// Stage sequencer and ping-pong address generator feeding the radix-2 Hartley butterfly.
module fht_addr_gen
    import fht_pkg::*;
#(
    parameter int N      = 16,
    parameter int A_BIT  = $clog2(N),
    parameter int WR_DLY = WR_DLY_DEF
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    output logic             oBUSY,
    output logic             oDONE,
    output logic [A_BIT-1:0] oSTAGE,
    output logic             oRD_BANK,
    output logic             oRD_EN_12,
    output logic [A_BIT-1:0] oRD_ADDR_1,
    output logic [A_BIT-1:0] oRD_ADDR_2,
    output logic [A_BIT-2:0] oCOEF_IDX,
    output logic             oRD_EN_0,
    output logic [A_BIT-1:0] oRD_ADDR_0,
    output logic             oWR_EN,
    output logic             oWR_BANK,
    output logic [A_BIT-1:0] oWR_ADDR_0,
    output logic [A_BIT-1:0] oWR_ADDR_1
);

    localparam int J_W = A_BIT - 1;
    localparam int D_W = (WR_DLY > 1) ? $clog2(WR_DLY) : 1;
    localparam int WR_W = 2 + 2 * A_BIT;

    localparam logic [J_W-1:0]   J_LAST = J_W'(N / 2 - 1);
    localparam logic [A_BIT-1:0] S_LAST = A_BIT'(A_BIT - 1);
    localparam logic [D_W-1:0]   D_LAST = D_W'(WR_DLY - 1);

    fht_state_e       state_q, state_d;
    logic [A_BIT-1:0] s_q, s_d;
    logic [J_W-1:0]   j_q, j_d;
    logic [D_W-1:0]   dcnt_q, dcnt_d;

    logic             vld_p0, busy_p0, done_p0;
    logic [A_BIT-1:0] j_ext, h, hmask, k, g;
    logic [A_BIT-1:0] x0_p0, x1_p0, x2_p0;
    logic [J_W-1:0]   coef_p0;

    logic             vld_p1, busy_p1, done_p1;
    logic [A_BIT-1:0] stage_p1, x0_p1, x1_p1, x2_p1;
    logic [J_W-1:0]   coef_p1;

    logic [A_BIT:0]   x0_dly_q;
    logic [WR_W-1:0]  wr_dly_d, wr_dly_q;

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            j_q     <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        dcnt_d  = dcnt_q;
        vld_p0  = 1'b0;
        busy_p0 = 1'b0;
        done_p0 = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            ST_RUN: begin
                vld_p0  = 1'b1;
                busy_p0 = 1'b1;
                if (j_q == J_LAST) begin
                    state_d = ST_DRAIN;
                    j_d     = '0;
                    dcnt_d  = '0;
                end else begin
                    j_d = j_q + J_W'(1);
                end
            end
            ST_DRAIN: begin
                // Next stage may only start once the last write of this one has landed.
                busy_p0 = 1'b1;
                if (dcnt_q == D_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        s_d     = s_q + A_BIT'(1);
                    end
                end else begin
                    dcnt_d = dcnt_q + D_W'(1);
                end
            end
            ST_DONE: begin
                done_p0 = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 0: butterfly addresses from (s, j); pairs sit h apart inside 2h-wide groups.
    always_comb begin
        j_ext   = {1'b0, j_q};
        h       = A_BIT'(1) << s_q;
        hmask   = h - A_BIT'(1);
        k       = j_ext & hmask;
        g       = (j_ext >> s_q) << (s_q + A_BIT'(1));
        x0_p0   = g + k;
        x1_p0   = g + h + k;
        x2_p0   = g + h + ((h - k) & hmask);
        coef_p0 = J_W'(k << (S_LAST - s_q));
    end

    // Stage 1: registered issue slot; addresses hold while no butterfly is issued.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            vld_p1   <= 1'b0;
            busy_p1  <= 1'b0;
            done_p1  <= 1'b0;
            stage_p1 <= '0;
            x0_p1    <= '0;
            x1_p1    <= '0;
            x2_p1    <= '0;
            coef_p1  <= '0;
        end else begin
            vld_p1   <= vld_p0;
            busy_p1  <= busy_p0;
            done_p1  <= done_p0;
            stage_p1 <= s_q;
            if (vld_p0) begin
                x0_p1   <= x0_p0;
                x1_p1   <= x1_p0;
                x2_p1   <= x2_p0;
                coef_p1 <= coef_p0;
            end
        end
    end

    // Stage 2 / write stage: x0 and the write slot are delayed copies of the issue slot.
    fht_dly_line #(
        .WIDTH (A_BIT + 1),
        .DEPTH (1)
    ) u_x0_dly (
        .clk   (iCLK),
        .rst_n (iRESET),
        .d     ({vld_p1, x0_p1}),
        .q     (x0_dly_q)
    );

    assign wr_dly_d = {vld_p1, ~stage_p1[0], x0_p1, x1_p1};

    fht_dly_line #(
        .WIDTH (WR_W),
        .DEPTH (WR_DLY)
    ) u_wr_dly (
        .clk   (iCLK),
        .rst_n (iRESET),
        .d     (wr_dly_d),
        .q     (wr_dly_q)
    );

    assign oBUSY      = busy_p1;
    assign oDONE      = done_p1;
    assign oSTAGE     = stage_p1;
    assign oRD_BANK   = stage_p1[0];
    assign oRD_EN_12  = vld_p1;
    assign oRD_ADDR_1 = x1_p1;
    assign oRD_ADDR_2 = x2_p1;
    assign oCOEF_IDX  = coef_p1;
    assign oRD_EN_0   = x0_dly_q[A_BIT];
    assign oRD_ADDR_0 = x0_dly_q[A_BIT-1:0];
    assign oWR_EN     = wr_dly_q[WR_W-1];
    assign oWR_BANK   = wr_dly_q[WR_W-2];
    assign oWR_ADDR_0 = wr_dly_q[2*A_BIT-1:A_BIT];
    assign oWR_ADDR_1 = wr_dly_q[A_BIT-1:0];

endmodule

// File: tb/tb_fht_addr_gen.sv
// Self-checking bench for fht_addr_gen: cycle schedule model plus a RAM/butterfly scoreboard.
module tb_fht_addr_gen;

    localparam int N      = 16;
    localparam int A_BIT  = 4;
    localparam int WR_DLY = 3;
    localparam int P      = N / 2 + WR_DLY;
    localparam int T_DONE = A_BIT * P + 1;
    localparam int NCYC   = T_DONE + 6;
    localparam real PI    = 3.14159265358979323846;

    logic             iCLK, iRESET, iSTART;
    logic             oBUSY, oDONE, oRD_BANK, oRD_EN_12, oRD_EN_0, oWR_EN, oWR_BANK;
    logic [A_BIT-1:0] oSTAGE, oRD_ADDR_1, oRD_ADDR_2, oRD_ADDR_0, oWR_ADDR_0, oWR_ADDR_1;
    logic [A_BIT-2:0] oCOEF_IDX;
    logic [33:0]      outs;

    fht_addr_gen #(.N(N), .A_BIT(A_BIT), .WR_DLY(WR_DLY)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .oBUSY(oBUSY), .oDONE(oDONE),
        .oSTAGE(oSTAGE), .oRD_BANK(oRD_BANK), .oRD_EN_12(oRD_EN_12),
        .oRD_ADDR_1(oRD_ADDR_1), .oRD_ADDR_2(oRD_ADDR_2), .oCOEF_IDX(oCOEF_IDX),
        .oRD_EN_0(oRD_EN_0), .oRD_ADDR_0(oRD_ADDR_0), .oWR_EN(oWR_EN), .oWR_BANK(oWR_BANK),
        .oWR_ADDR_0(oWR_ADDR_0), .oWR_ADDR_1(oWR_ADDR_1)
    );

    assign outs = {oBUSY, oDONE, oSTAGE, oRD_BANK, oRD_EN_12, oRD_ADDR_1, oRD_ADDR_2, oCOEF_IDX,
                   oRD_EN_0, oRD_ADDR_0, oWR_EN, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1};

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected per-cycle schedule, cycle 0 = edge that samples iSTART.
    bit               e_rd12 [NCYC];
    bit               e_rd0  [NCYC];
    bit               e_wr   [NCYC];
    logic [A_BIT-1:0] e_a0 [NCYC], e_a1 [NCYC], e_a2 [NCYC], e_stage [NCYC];
    logic [A_BIT-1:0] e_y0 [NCYC], e_y1 [NCYC];
    logic [A_BIT-2:0] e_coef [NCYC];
    bit               e_wb [NCYC];

    task automatic build_sched();
        for (int c = 0; c < NCYC; c++) begin
            e_rd12[c] = 0; e_rd0[c] = 0; e_wr[c] = 0;
        end
        for (int s = 0; s < A_BIT; s++) begin
            int h, c, x0, x1, x2;
            h = 1 << s;
            for (int blk = 0; blk < N / (2 * h); blk++) begin
                for (int k = 0; k < h; k++) begin
                    c  = 1 + s * P + blk * h + k;
                    x0 = blk * 2 * h + k;
                    x1 = x0 + h;
                    x2 = (k == 0) ? blk * 2 * h + h : blk * 2 * h + 2 * h - k;
                    e_rd12[c] = 1; e_a1[c] = A_BIT'(x1); e_a2[c] = A_BIT'(x2);
                    e_coef[c] = (A_BIT-1)'(k * (N / (2 * h))); e_stage[c] = A_BIT'(s);
                    e_rd0[c + 1] = 1; e_a0[c + 1] = A_BIT'(x0);
                    e_wr[c + WR_DLY] = 1; e_wb[c + WR_DLY] = ((s % 2) == 0);
                    e_y0[c + WR_DLY] = A_BIT'(x0); e_y1[c + WR_DLY] = A_BIT'(x1);
                end
            end
        end
    endtask

    // Leaves the caller at the observation point of cycle 0.
    task automatic start_pulse();
        @(negedge iCLK);
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < A_BIT; b++) if (v & (1 << b)) r |= 1 << (A_BIT - 1 - b);
        return r;
    endfunction

    task automatic test_reset();
        iRESET = 1'b0;
        iSTART = 1'b1;
        repeat (3) @(negedge iCLK);
        n_cmp++;
        if (outs !== 34'd0) begin
            n_bad++; $display("FAIL reset_outs got=%h exp=0", outs);
        end
        iSTART = 1'b0;
        iRESET = 1'b1;
        repeat (3) @(negedge iCLK);
        n_cmp++;
        if (oBUSY !== 1'b0 || oRD_EN_12 !== 1'b0) begin
            n_bad++; $display("FAIL reset_beats_start busy=%b rd12=%b exp=0", oBUSY, oRD_EN_12);
        end
    endtask

    task automatic test_full_run();
        int wr_cnt = 0;
        int seen [A_BIT][N];
        int bank_seq [$];
        int last_stage = -1;
        for (int s = 0; s < A_BIT; s++) for (int a = 0; a < N; a++) seen[s][a] = 0;
        start_pulse();
        for (int c = 1; c < NCYC; c++) begin
            @(negedge iCLK);
            n_cmp += 5;
            if (oRD_EN_12 !== e_rd12[c]) begin n_bad++; $display("FAIL rd12 c=%0d got=%b exp=%b", c, oRD_EN_12, e_rd12[c]); end
            if (oRD_EN_0 !== e_rd0[c]) begin n_bad++; $display("FAIL rd0 c=%0d got=%b exp=%b", c, oRD_EN_0, e_rd0[c]); end
            if (oWR_EN !== e_wr[c]) begin n_bad++; $display("FAIL wr_en c=%0d got=%b exp=%b", c, oWR_EN, e_wr[c]); end
            if (oBUSY !== (c < T_DONE)) begin n_bad++; $display("FAIL busy c=%0d got=%b exp=%b", c, oBUSY, c < T_DONE); end
            if (oDONE !== (c == T_DONE)) begin n_bad++; $display("FAIL done c=%0d got=%b exp=%b", c, oDONE, c == T_DONE); end
            if (e_rd12[c]) begin
                n_cmp++;
                if ({oRD_ADDR_1, oRD_ADDR_2, oCOEF_IDX, oSTAGE, oRD_BANK} !==
                    {e_a1[c], e_a2[c], e_coef[c], e_stage[c], e_stage[c][0]}) begin
                    n_bad++;
                    $display("FAIL rd_addr c=%0d got x1=%0d x2=%0d coef=%0d s=%0d bank=%b exp x1=%0d x2=%0d coef=%0d s=%0d",
                             c, oRD_ADDR_1, oRD_ADDR_2, oCOEF_IDX, oSTAGE, oRD_BANK, e_a1[c], e_a2[c], e_coef[c], e_stage[c]);
                end
                if (int'(oSTAGE) != last_stage) begin
                    last_stage = int'(oSTAGE);
                    bank_seq.push_back(int'(oRD_BANK));
                end
            end
            if (e_rd0[c]) begin
                n_cmp++;
                if (oRD_ADDR_0 !== e_a0[c]) begin n_bad++; $display("FAIL x0 c=%0d got=%0d exp=%0d", c, oRD_ADDR_0, e_a0[c]); end
            end
            if (e_wr[c]) begin
                n_cmp++;
                if ({oWR_BANK, oWR_ADDR_0, oWR_ADDR_1} !== {e_wb[c], e_y0[c], e_y1[c]}) begin
                    n_bad++;
                    $display("FAIL wr_addr c=%0d got bank=%b y0=%0d y1=%0d exp bank=%b y0=%0d y1=%0d",
                             c, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1, e_wb[c], e_y0[c], e_y1[c]);
                end
            end
            if (oWR_EN === 1'b1) begin
                if (wr_cnt / (N / 2) < A_BIT) begin
                    seen[wr_cnt / (N / 2)][oWR_ADDR_0]++;
                    seen[wr_cnt / (N / 2)][oWR_ADDR_1]++;
                end
                wr_cnt++;
            end
            if (c == 1) begin
                n_cmp++;
                if ({oRD_ADDR_1, oRD_ADDR_2, oCOEF_IDX} !== {4'd1, 4'd1, 3'd0}) begin
                    n_bad++; $display("FAIL first_issue got x1=%0d x2=%0d coef=%0d exp 1 1 0", oRD_ADDR_1, oRD_ADDR_2, oCOEF_IDX);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if ({oWR_EN, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1} !== {1'b1, 1'b1, 4'd0, 4'd1}) begin
                    n_bad++; $display("FAIL first_write got en=%b bank=%b y0=%0d y1=%0d exp 1 1 0 1", oWR_EN, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1);
                end
            end
        end
        n_cmp++;
        if (wr_cnt != A_BIT * N / 2) begin n_bad++; $display("FAIL wr_count got=%0d exp=%0d", wr_cnt, A_BIT * N / 2); end
        for (int s = 0; s < A_BIT; s++) begin
            int ok = 1;
            for (int a = 0; a < N; a++) if (seen[s][a] != 1) ok = 0;
            n_cmp++;
            if (ok == 0) begin n_bad++; $display("FAIL wr_cover stage=%0d got=incomplete exp=each address once", s); end
        end
        n_cmp++;
        if (bank_seq.size() != A_BIT) begin
            n_bad++; $display("FAIL rd_bank_len got=%0d exp=%0d", bank_seq.size(), A_BIT);
        end else begin
            for (int s = 0; s < A_BIT; s++) begin
                n_cmp++;
                if (bank_seq[s] != s % 2) begin n_bad++; $display("FAIL rd_bank stage=%0d got=%0d exp=%0d", s, bank_seq[s], s % 2); end
            end
        end
    endtask

    task automatic test_start_ignored();
        int pulse_c, done_c, busy_n;
        pulse_c = 1 + P + int'($urandom_range(0, N / 2 - 1));
        done_c  = -1;
        busy_n  = 0;
        start_pulse();
        for (int c = 1; c < NCYC; c++) begin
            @(negedge iCLK);
            iSTART = (c == pulse_c);
            if (oDONE === 1'b1 && done_c < 0) done_c = c;
            if (oBUSY === 1'b1) busy_n++;
        end
        iSTART = 1'b0;
        n_cmp += 2;
        if (done_c != T_DONE) begin n_bad++; $display("FAIL ignored_start_done got=%0d exp=%0d", done_c, T_DONE); end
        if (busy_n != T_DONE - 1) begin n_bad++; $display("FAIL ignored_start_busy got=%0d exp=%0d", busy_n, T_DONE - 1); end
    endtask

    task automatic test_reset_mid();
        int done_n = 0, busy_n = 0, done_c = -1;
        start_pulse();
        for (int c = 1; c < 20; c++) @(negedge iCLK);
        iRESET = 1'b0;
        @(negedge iCLK);
        iRESET = 1'b1;
        n_cmp++;
        if (outs !== 34'd0) begin n_bad++; $display("FAIL mid_reset_outs got=%h exp=0", outs); end
        repeat (40) begin
            @(negedge iCLK);
            if (oDONE === 1'b1) done_n++;
            if (oBUSY === 1'b1 || oRD_EN_12 === 1'b1 || oWR_EN === 1'b1) busy_n++;
        end
        n_cmp += 2;
        if (done_n != 0) begin n_bad++; $display("FAIL mid_reset_done got=%0d exp=0", done_n); end
        if (busy_n != 0) begin n_bad++; $display("FAIL mid_reset_activity got=%0d exp=0", busy_n); end
        start_pulse();
        @(negedge iCLK);
        n_cmp++;
        if ({oRD_EN_12, oSTAGE, oRD_ADDR_1, oRD_ADDR_2, oCOEF_IDX} !== {1'b1, 4'd0, 4'd1, 4'd1, 3'd0}) begin
            n_bad++; $display("FAIL restart got en=%b s=%0d x1=%0d x2=%0d coef=%0d exp 1 0 1 1 0",
                              oRD_EN_12, oSTAGE, oRD_ADDR_1, oRD_ADDR_2, oCOEF_IDX);
        end
        for (int c = 2; c < NCYC; c++) begin
            @(negedge iCLK);
            if (oDONE === 1'b1 && done_c < 0) done_c = c;
        end
        n_cmp++;
        if (done_c != T_DONE) begin n_bad++; $display("FAIL restart_done got=%0d exp=%0d", done_c, T_DONE); end
    endtask

    task automatic test_scoreboard();
        int  bank [2][N];
        int  x [N];
        int  q1 [$], q2 [$], qc [$], q0 [$];
        int  underflow = 0;
        int  done_c = -1;
        real t, ang, ref_v, err;
        int  rb, a, b, cf, y0v, y1v;
        for (int n = 0; n < N; n++) begin
            x[n] = int'($urandom_range(0, 4095)) - 2048;
            bank[0][bitrev(n)] = x[n];
            bank[1][n] = int'($urandom_range(0, 255));
        end
        start_pulse();
        for (int c = 1; c < NCYC; c++) begin
            @(negedge iCLK);
            if (oDONE === 1'b1 && done_c < 0) done_c = c;
            if (oWR_EN === 1'b1) begin
                if (q1.size() == 0 || q0.size() == 0) begin
                    underflow++;
                end else begin
                    a = q1.pop_front(); b = q2.pop_front(); cf = qc.pop_front();
                    ang = 2.0 * PI * real'(cf) / real'(N);
                    t   = real'(a) * $cos(ang) + real'(b) * $sin(ang);
                    y0v = int'((real'(q0[0]) + t) / 2.0);
                    y1v = int'((real'(q0[0]) - t) / 2.0);
                    void'(q0.pop_front());
                    bank[oWR_BANK][oWR_ADDR_0] = y0v;
                    bank[oWR_BANK][oWR_ADDR_1] = y1v;
                end
            end
            rb = int'(oRD_BANK);
            if (oRD_EN_12 === 1'b1) begin
                q1.push_back(bank[rb][oRD_ADDR_1]);
                q2.push_back(bank[rb][oRD_ADDR_2]);
                qc.push_back(int'(oCOEF_IDX));
            end
            if (oRD_EN_0 === 1'b1) q0.push_back(bank[rb][oRD_ADDR_0]);
        end
        n_cmp += 3;
        if (done_c != T_DONE) begin n_bad++; $display("FAIL sb_done got=%0d exp=%0d", done_c, T_DONE); end
        if (underflow != 0) begin n_bad++; $display("FAIL sb_underflow got=%0d exp=0", underflow); end
        if (q1.size() + q0.size() != 0) begin n_bad++; $display("FAIL sb_leftover got=%0d exp=0", q1.size() + q0.size()); end
        for (int kk = 0; kk < N; kk++) begin
            ref_v = 0.0;
            for (int n = 0; n < N; n++) begin
                ang   = 2.0 * PI * real'(n * kk) / real'(N);
                ref_v = ref_v + real'(x[n]) * ($cos(ang) + $sin(ang));
            end
            ref_v = ref_v / real'(N);
            err   = real'(bank[A_BIT % 2][kk]) - ref_v;
            if (err < 0.0) err = -err;
            n_cmp++;
            if (err >= real'(A_BIT)) begin
                n_bad++; $display("FAIL sb_fht k=%0d got=%0d exp=%0.2f", kk, bank[A_BIT % 2][kk], ref_v);
            end
        end
    endtask

    initial begin
        iRESET = 1'b0;
        iSTART = 1'b0;
        build_sched();
        test_reset();
        test_full_run();
        repeat (int'($urandom_range(0, 5))) @(negedge iCLK);
        test_start_ignored();
        test_reset_mid();
        repeat (2) test_scoreboard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
